// File: rtl/input_current_scheduler_if.sv
// Bundle between the scheduler, the external weight memory and the
// membrane-update stage.
//   weight_rd_en / weight_addr : read strobe and address into the weight memory
//   weight_rdata               : signed weight, valid one cycle after weight_rd_en
//   current_valid / ready      : handshake for one current per neuron
//   current_neuron / data      : neuron index and saturated signed current
// master = scheduler side, slave = memory/consumer side.
interface input_current_scheduler_if #(
  parameter int W  = 8,
  parameter int AW = 4,
  parameter int NW = 2
);
  logic          weight_rd_en;
  logic [AW-1:0] weight_addr;
  logic [W-1:0]  weight_rdata;
  logic          current_valid;
  logic          current_ready;
  logic [NW-1:0] current_neuron;
  logic [W-1:0]  current_data;

  modport master (
    output weight_rd_en, weight_addr, current_valid, current_neuron, current_data,
    input  weight_rdata, current_ready
  );

  modport slave (
    input  weight_rd_en, weight_addr, current_valid, current_neuron, current_data,
    output weight_rdata, current_ready
  );
endinterface

// File: rtl/input_current_scheduler.sv
// Time-multiplexed weight-sum/saturate datapath for one layer. On start the
// spike vector is latched and every neuron's M weights are read, one per
// cycle; weights whose spike bit is set are summed, the sum is clamped to W
// bits and presented over a valid/ready handshake.
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : begin a timestep (only honoured in IDLE)
//   input_spikes   : M-bit spike vector, latched on start
//   busy, done     : busy outside IDLE; done pulses after the last handshake
//   bus (master)   : weight memory read port and current output stream
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | issuing M weight reads for the current neuron
// FLUSH | last read returns and is accumulated
// OUT   | current presented, waiting for current_ready
module input_current_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int M         = 4,
  parameter int W         = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [M-1:0]                input_spikes,
  output logic                        busy,
  output logic                        done,
  input_current_scheduler_if.master   bus
);
  localparam int AW  = $clog2(N_NEURONS*M);
  localparam int NW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int SW  = (M > 1) ? $clog2(M) : 1;
  localparam int ACC = W + $clog2(M) + 1;

  localparam logic [NW-1:0] LAST_N = NW'(N_NEURONS-1);
  localparam logic [SW-1:0] LAST_S = SW'(M-1);
  localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUT} state_t;

  state_t                 state;
  logic [M-1:0]           spikes;
  logic [NW-1:0]          neuron;
  logic [SW-1:0]          syn;
  logic                   rd_d;
  logic                   spk_d;
  logic signed [ACC-1:0]  acc;
  logic signed [ACC-1:0]  addend;
  logic signed [ACC-1:0]  acc_next;
  logic [W-1:0]           sat_val;

  function automatic logic [AW-1:0] addr_of(input logic [NW-1:0] n, input logic [SW-1:0] s);
    return AW'(int'(n) * M + int'(s));
  endfunction

  // rd_d/spk_d describe the read whose data is on weight_rdata this cycle.
  always_comb begin
    addend = '0;
    if (rd_d && spk_d)
      addend = {{(ACC-W){bus.weight_rdata[W-1]}}, bus.weight_rdata};
    acc_next = acc + addend;
  end

  // Saturate the sum that includes the final weight, so OUT can be entered
  // straight from FLUSH with a registered current.
  always_comb begin
    if (acc_next > SAT_MAX)
      sat_val = {1'b0, {(W-1){1'b1}}};
    else if (acc_next < SAT_MIN)
      sat_val = {1'b1, {(W-1){1'b0}}};
    else
      sat_val = acc_next[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      spikes             <= '0;
      neuron             <= '0;
      syn                <= '0;
      rd_d               <= 1'b0;
      spk_d              <= 1'b0;
      acc                <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      bus.weight_rd_en   <= 1'b0;
      bus.weight_addr    <= '0;
      bus.current_valid  <= 1'b0;
      bus.current_neuron <= '0;
      bus.current_data   <= '0;
    end else begin
      done  <= 1'b0;
      rd_d  <= bus.weight_rd_en;
      spk_d <= spikes[syn];
      acc   <= acc_next;
      case (state)
        IDLE: begin
          if (start) begin
            spikes           <= input_spikes;
            neuron           <= '0;
            syn              <= '0;
            acc              <= '0;
            bus.weight_rd_en <= 1'b1;
            bus.weight_addr  <= '0;
            busy             <= 1'b1;
            state            <= ACCUM;
          end
        end
        ACCUM: begin
          if (syn == LAST_S) begin
            bus.weight_rd_en <= 1'b0;
            state            <= FLUSH;
          end else begin
            syn             <= SW'(syn + 1'b1);
            bus.weight_addr <= addr_of(neuron, SW'(syn + 1'b1));
          end
        end
        FLUSH: begin
          bus.current_valid  <= 1'b1;
          bus.current_neuron <= neuron;
          bus.current_data   <= sat_val;
          state              <= OUT;
        end
        OUT: begin
          if (bus.current_ready) begin
            bus.current_valid <= 1'b0;
            if (neuron == LAST_N) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              neuron           <= NW'(neuron + 1'b1);
              syn              <= '0;
              acc              <= '0;
              bus.weight_rd_en <= 1'b1;
              bus.weight_addr  <= addr_of(NW'(neuron + 1'b1), '0);
              state            <= ACCUM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
